// File: rtl/fetch_rf_1p_arb.sv
// rtl/fetch_rf_1p_arb.sv - single-port fetch register file with write-over-read arbitration
//
// Purpose:
//   Word-addressed register file of 2**ADDR_WIDTH words, PIX_NUM pixels of
//   PIX_WIDTH bits each. The array allows one access per cycle. Writes always
//   win. A read that arrives alongside a write waits in a one-entry pending
//   slot. Read data is registered and held between valid pulses.
//
// Ports:
//   clk          - clock
//   rstn         - asynchronous active-low reset
//   wrif_en_i    - write request (always accepted)
//   wrif_addr_i  - write word address
//   wrif_mask_i  - per-pixel write enable, bit k covers pixel k
//   wrif_data_i  - write data, pixel k at [k*PIX_WIDTH +: PIX_WIDTH]
//   rdif_en_i    - read request
//   rdif_addr_i  - read word address
//   rdif_ready_o - read request can be accepted this cycle
//   rdif_valid_o - one-cycle pulse, rdif_pdata_o carries new data
//   rdif_pdata_o - read data, held until the next valid

module fetch_rf_1p_arb #(
    parameter int ADDR_WIDTH = 6,
    parameter int PIX_NUM    = 32,
    parameter int PIX_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           wrif_en_i,
    input  logic [ADDR_WIDTH-1:0]          wrif_addr_i,
    input  logic [PIX_NUM-1:0]             wrif_mask_i,
    input  logic [PIX_NUM*PIX_WIDTH-1:0]   wrif_data_i,
    input  logic                           rdif_en_i,
    input  logic [ADDR_WIDTH-1:0]          rdif_addr_i,
    output logic                           rdif_ready_o,
    output logic                           rdif_valid_o,
    output logic [PIX_NUM*PIX_WIDTH-1:0]   rdif_pdata_o
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int WORD_W = PIX_NUM * PIX_WIDTH;

    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic                  r_pend_vld;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic                  r_valid;
    logic [WORD_W-1:0]     r_pdata;

    logic                  w_rd_acc;
    logic                  w_do_read;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign rdif_ready_o = ~r_pend_vld;
    assign w_rd_acc     = rdif_en_i & ~r_pend_vld;

    // The port goes to the array read only when no write is present; a
    // pending read always outranks a newly accepted one (which cannot exist
    // anyway, since ready is low while the slot is full).
    assign w_do_read    = ~wrif_en_i & (r_pend_vld | w_rd_acc);
    assign w_rd_addr    = r_pend_vld ? r_pend_addr : rdif_addr_i;

    // Array contents carry no reset; only masked pixels are overwritten.
    always_ff @(posedge clk) begin
        if (wrif_en_i) begin
            for (int k = 0; k < PIX_NUM; k++) begin
                if (wrif_mask_i[k]) begin
                    r_mem[wrif_addr_i][k*PIX_WIDTH +: PIX_WIDTH] <= wrif_data_i[k*PIX_WIDTH +: PIX_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
        end else if (wrif_en_i) begin
            // A read accepted under a write parks in the slot; an already
            // parked read simply keeps waiting.
            if (w_rd_acc) begin
                r_pend_vld  <= 1'b1;
                r_pend_addr <= rdif_addr_i;
            end
        end else if (r_pend_vld) begin
            r_pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_pdata <= '0;
        end else begin
            r_valid <= w_do_read;
            if (w_do_read) begin
                r_pdata <= r_mem[w_rd_addr];
            end
        end
    end

    assign rdif_valid_o = r_valid;
    assign rdif_pdata_o = r_pdata;

endmodule

// File: tb/tb_fetch_rf_1p_arb.sv
// tb/tb_fetch_rf_1p_arb.sv - scoreboard bench for fetch_rf_1p_arb

module tb_fetch_rf_1p_arb;

    localparam int AW    = 6;
    localparam int PN    = 32;
    localparam int PW    = 8;
    localparam int W     = PN * PW;
    localparam int DEPTH = 2 ** AW;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wrif_en_i = 1'b0;
    logic [AW-1:0] wrif_addr_i = '0;
    logic [PN-1:0] wrif_mask_i = '0;
    logic [W-1:0]  wrif_data_i = '0;
    logic          rdif_en_i = 1'b0;
    logic [AW-1:0] rdif_addr_i = '0;
    logic          rdif_ready_o;
    logic          rdif_valid_o;
    logic [W-1:0]  rdif_pdata_o;

    fetch_rf_1p_arb #(.ADDR_WIDTH(AW), .PIX_NUM(PN), .PIX_WIDTH(PW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wrif_en_i    (wrif_en_i),
        .wrif_addr_i  (wrif_addr_i),
        .wrif_mask_i  (wrif_mask_i),
        .wrif_data_i  (wrif_data_i),
        .rdif_en_i    (rdif_en_i),
        .rdif_addr_i  (rdif_addr_i),
        .rdif_ready_o (rdif_ready_o),
        .rdif_valid_o (rdif_valid_o),
        .rdif_pdata_o (rdif_pdata_o)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] model_mem [DEPTH];
    logic [AW-1:0] pend_q [$];
    exp_t         exp_q [$];
    logic [W-1:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] fill(input logic [PW-1:0] b);
        logic [W-1:0] r;
        for (int k = 0; k < PN; k++) r[k*PW +: PW] = b;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: pops the scoreboard on every valid, checks hold otherwise.
    always @(negedge clk) begin
        if (rstn) begin
            if (rdif_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid at cycle %0d pdata=%h", cyc, rdif_pdata_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rdif_pdata_o !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL read_data cycle %0d (required %0d) got %h required %h",
                                 cyc, e.cyc, rdif_pdata_o, e.data);
                    end
                    last_data = e.data;
                end
            end else begin
                checks++;
                if (rdif_pdata_o !== last_data) begin
                    errors++;
                    $display("FAIL pdata_hold cycle %0d got %h required %h", cyc, rdif_pdata_o, last_data);
                end
            end
        end
    end

    // Drives one cycle of stimulus (called just after a rising edge) and
    // advances the reference model by the arbitration rules.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [PN-1:0] wm,
                        input logic [W-1:0] wd, input logic re, input logic [AW-1:0] ra);
        logic ready;
        logic acc;
        logic [AW-1:0] a;
        ready = (pend_q.size() == 0);
        checks++;
        if (rdif_ready_o !== ready) begin
            errors++;
            $display("FAIL ready cycle %0d got %b required %b", cyc, rdif_ready_o, ready);
        end
        wrif_en_i = we; wrif_addr_i = wa; wrif_mask_i = wm; wrif_data_i = wd;
        rdif_en_i = re; rdif_addr_i = ra;
        acc = re && ready;
        if (we) begin
            for (int k = 0; k < PN; k++)
                if (wm[k]) model_mem[wa][k*PW +: PW] = wd[k*PW +: PW];
            if (acc) pend_q.push_back(ra);
        end else if (pend_q.size() > 0) begin
            a = pend_q.pop_front();
            exp_q.push_back('{data: model_mem[a], cyc: cyc + 1});
        end else if (acc) begin
            exp_q.push_back('{data: model_mem[ra], cyc: cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [PN-1:0] m, input logic [W-1:0] d);
        step(1'b1, a, m, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, '0, '0, '0, 1'b1, a);
    endtask

    initial begin
        logic [W-1:0] ramp;
        for (int k = 0; k < PN; k++) ramp[k*PW +: PW] = PW'(k);

        #12;
        // Reset state, sampled while reset is held.
        checks++;
        if (rdif_valid_o !== 1'b0 || rdif_pdata_o !== '0 || rdif_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got valid=%b ready=%b pdata=%h required valid=0 ready=1 pdata=0",
                     rdif_valid_o, rdif_ready_o, rdif_pdata_o);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Define every word so random reads never hit uninitialised storage.
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), '1, rand_word());

        // Full-mask write then direct read, data held afterwards.
        wr(6'd5, '1, ramp);
        rd(6'd5);
        idle(3);

        // Partial mask.
        wr(6'd5, '1, fill(8'hAA));
        wr(6'd5, 32'h0000_000F, fill(8'h55));
        rd(6'd5);
        idle(2);

        // Zero mask is a no-op write that still blocks a read.
        step(1'b1, 6'd5, '0, fill(8'hEE), 1'b1, 6'd5);
        idle(3);

        // Simultaneous write and read to the same address.
        step(1'b1, 6'd3, '1, fill(8'h11), 1'b1, 6'd3);
        idle(3);

        // Pending read of 7 held off by three writes to 7.
        step(1'b1, 6'd0, '1, fill(8'h01), 1'b1, 6'd7);
        wr(6'd7, '1, fill(8'h70));
        wr(6'd7, '1, fill(8'h71));
        wr(6'd7, '1, fill(8'h77));
        idle(3);

        // Read pulsed while ready is low is ignored.
        step(1'b1, 6'd9, '1, fill(8'h99), 1'b1, 6'd9);
        rd(6'd5);
        idle(4);

        // Reset with a pending read outstanding.
        step(1'b1, 6'd2, '1, fill(8'h22), 1'b1, 6'd2);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (rdif_valid_o !== 1'b0 || rdif_pdata_o !== '0 || rdif_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got valid=%b ready=%b pdata=%h required valid=0 ready=1 pdata=0",
                     rdif_valid_o, rdif_ready_o, rdif_pdata_o);
        end
        pend_q.delete();
        exp_q.delete();
        last_data = '0;
        wrif_en_i = 1'b0;
        rdif_en_i = 1'b0;
        @(posedge clk); #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        idle(4);

        // Randomised traffic, addresses confined to a few words for collisions.
        for (int i = 0; i < 1500; i++) begin
            logic          we, re;
            logic [AW-1:0] wa, ra;
            logic [PN-1:0] wm;
            int            msel;
            we = ($urandom_range(0, 99) < 40);
            re = ($urandom_range(0, 99) < 55);
            wa = AW'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            msel = $urandom_range(0, 3);
            wm = (msel == 0) ? '1 : (msel == 1) ? '0 : PN'($urandom);
            step(we, wa, wm, rand_word(), re, ra);
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && (exp_q.size() != 0 || pend_q.size() != 0); i++) idle(1);
        idle(2);
        checks++;
        if (exp_q.size() != 0 || pend_q.size() != 0) begin
            errors++;
            $display("FAIL drain outstanding=%0d required 0", exp_q.size() + pend_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
